// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run/halt/step/burst sequencer with PC breakpoint for the core step enable
module cpu_run_controller #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   halt_in,
    input  logic                   step_in,
    input  logic                   burst_in,
    input  logic [COUNT_WIDTH-1:0] burst_len_in,
    input  logic                   bp_enable_in,
    input  logic [31:0]            bp_addr_in,
    input  logic [31:0]            pc_in,
    output logic                   cpu_step_out,
    output logic [1:0]             state_out,
    output logic [31:0]            steps_out,
    output logic                   bp_hit_out
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_STEP   = 2'd2,
        S_BURST  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [COUNT_WIDTH-1:0] w_cnt_nxt;
    logic                   r_skip;
    logic                   w_skip_nxt;
    logic [31:0]            r_steps;
    logic                   r_bp_hit;
    logic                   w_bp_hit_nxt;
    logic                   w_base;
    logic                   w_bp_match;
    logic                   w_step;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= S_HALTED;
            r_cnt    <= '0;
            r_skip   <= 1'b0;
            r_steps  <= '0;
            r_bp_hit <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_skip   <= w_skip_nxt;
            r_bp_hit <= w_bp_hit_nxt;
            if (w_step) begin
                r_steps <= r_steps + 32'd1;
            end
        end
    end

    always_comb begin
        w_base       = (r_state != S_HALTED);
        // Breakpoints are ignored in STEP so a single step can execute the breakpointed instruction
        w_bp_match   = bp_enable_in && (pc_in == bp_addr_in) &&
                       ((r_state == S_RUN) || (r_state == S_BURST)) && !r_skip;
        w_step       = w_base && !w_bp_match;
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bp_hit_nxt = 1'b0;
        w_skip_nxt   = w_step ? 1'b0 : r_skip;

        case (r_state)
            S_HALTED: begin
                if (!halt_in) begin
                    w_state_nxt = S_RUN;
                    w_skip_nxt  = 1'b1;
                end else if (step_in) begin
                    w_state_nxt = S_STEP;
                end else if (burst_in && (burst_len_in != '0)) begin
                    w_state_nxt = S_BURST;
                    w_cnt_nxt   = burst_len_in;
                    w_skip_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                if (w_bp_match) begin
                    w_state_nxt  = S_HALTED;
                    w_bp_hit_nxt = 1'b1;
                end else if (halt_in) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_STEP: begin
                w_state_nxt = S_HALTED;
            end
            S_BURST: begin
                if (w_bp_match) begin
                    w_state_nxt  = S_HALTED;
                    w_bp_hit_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                end else if (!halt_in) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - COUNT_WIDTH'(1);
                    if (r_cnt == COUNT_WIDTH'(1)) begin
                        w_state_nxt = S_HALTED;
                    end
                end
            end
            default: begin
                w_state_nxt = S_HALTED;
            end
        endcase

        if (w_state_nxt == S_HALTED) begin
            w_skip_nxt = 1'b0;
        end
    end

    assign cpu_step_out = w_step;
    assign state_out    = r_state;
    assign steps_out    = r_steps;
    assign bp_hit_out   = r_bp_hit;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - scoreboard bench for cpu_run_controller
module tb_cpu_run_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        step;
    logic        burst;
    logic [15:0] burst_len;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_step;
    logic [1:0]  state;
    logic [31:0] steps;
    logic        bp_hit;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cyc;
        string       nm;
        logic        s;
        logic [1:0]  st;
        logic [31:0] steps;
        logic        hit;
    } exp_t;

    exp_t q[$];

    cpu_run_controller #(.COUNT_WIDTH(16)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .halt_in      (halt),
        .step_in      (step),
        .burst_in     (burst),
        .burst_len_in (burst_len),
        .bp_enable_in (bp_en),
        .bp_addr_in   (bp_addr),
        .pc_in        (pc),
        .cpu_step_out (cpu_step),
        .state_out    (state),
        .steps_out    (steps),
        .bp_hit_out   (bp_hit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: fetch PC advances by 4 on every enabled step
    always @(posedge clk or posedge rst) begin
        if (rst) pc <= 32'd0;
        else if (cpu_step) pc <= pc + 32'd4;
    end

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic s, input logic [1:0] st,
                       input logic [31:0] stp, input logic hit);
        exp_t e;
        e.cyc = cyc; e.nm = nm; e.s = s; e.st = st; e.steps = stp; e.hit = hit;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                total++;
                if (cpu_step !== e.s || state !== e.st || steps !== e.steps || bp_hit !== e.hit) begin
                    bad++;
                    $display("FAIL %s: got step=%0b state=%0d steps=%h hit=%0b, want step=%0b state=%0d steps=%h hit=%0b",
                             e.nm, cpu_step, state, steps, bp_hit, e.s, e.st, e.steps, e.hit);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : driver
        rst = 1'b1; halt = 1'b1; step = 1'b0; burst = 1'b0;
        burst_len = '0; bp_en = 1'b0; bp_addr = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 0, 1, 0, 0);
        rst = 1'b0;
        nx(); chk("reset_idle", 0, 1, 0, 0);

        for (int k = 0; k < 3; k++) begin
            nx(); step = 1'b1; chk("step_req", 0, 1, k, 0);
            nx(); step = 1'b0; chk("step_exec", 1, 2, k, 0);
            nx(); chk("step_done", 0, 1, k + 1, 0);
            nx(); nx();
        end

        nx(); burst = 1'b1; burst_len = 16'd10; chk("burst_req", 0, 1, 3, 0);
        for (int i = 0; i < 10; i++) begin
            nx(); burst = 1'b0; chk("burst_run", 1, 3, 3 + i, 0);
        end
        nx(); chk("burst_done", 0, 1, 13, 0);

        nx(); burst = 1'b1; burst_len = 16'd0; chk("burst0_req", 0, 1, 13, 0);
        nx(); burst = 1'b0; chk("burst0_ign", 0, 1, 13, 0);
        nx(); chk("burst0_ign2", 0, 1, 13, 0);

        nx(); step = 1'b1; burst = 1'b1; burst_len = 16'd5; chk("both_req", 0, 1, 13, 0);
        nx(); step = 1'b0; burst = 1'b0; chk("both_step", 1, 2, 13, 0);
        nx(); chk("both_done", 0, 1, 14, 0);
        nx(); chk("both_idle", 0, 1, 14, 0);

        nx(); burst = 1'b1; burst_len = 16'd5; chk("hd_req", 0, 1, 14, 0);
        nx(); burst = 1'b0; chk("hd_b1", 1, 3, 14, 0);
        nx(); halt = 1'b0; chk("hd_b2", 1, 3, 15, 0);
        nx(); chk("hd_run1", 1, 0, 16, 0);
        nx(); chk("hd_run2", 1, 0, 17, 0);
        nx(); chk("hd_run3", 1, 0, 18, 0); halt = 1'b1;
        nx(); chk("hd_halt", 0, 1, 19, 0);
        nx(); chk("hd_halt2", 0, 1, 19, 0);

        nx();
        force dut.r_steps = 32'hFFFF_FFFE;
        #1;
        release dut.r_steps;
        chk("wrap_pre", 0, 1, 32'hFFFF_FFFE, 0);
        nx(); burst = 1'b1; burst_len = 16'd3; chk("wrap_req", 0, 1, 32'hFFFF_FFFE, 0);
        nx(); burst = 1'b0; chk("wrap_b1", 1, 3, 32'hFFFF_FFFE, 0);
        nx(); chk("wrap_b2", 1, 3, 32'hFFFF_FFFF, 0);
        nx(); chk("wrap_b3", 1, 3, 32'h0, 0);
        nx(); chk("wrap_done", 0, 1, 32'h1, 0);

        nx(); burst = 1'b1; burst_len = 16'd20; chk("rb_req", 0, 1, 1, 0);
        nx(); burst = 1'b0; chk("rb_b1", 1, 3, 1, 0);
        nx(); chk("rst_async", 0, 1, 0, 0);
        #2 rst = 1'b1;
        nx(); chk("rst_hold", 0, 1, 0, 0);
        nx(); rst = 1'b0; chk("rst_rel", 0, 1, 0, 0);
        nx(); chk("rst_idle", 0, 1, 0, 0);

        bp_en = 1'b1; bp_addr = 32'h40;
        nx(); burst = 1'b1; burst_len = 16'd100; chk("bb_req", 0, 1, 0, 0);
        nx(); burst = 1'b0; chk("bb_first", 1, 3, 0, 0);
        repeat (15) nx();
        chk("bb_16", 1, 3, 15, 0);
        nx(); chk("bb_match", 0, 3, 16, 0);
        nx(); chk("bb_hit", 0, 1, 16, 1);
        nx(); step = 1'b1; chk("bb_after", 0, 1, 16, 0);
        nx(); step = 1'b0; chk("bb_step", 1, 2, 16, 0);
        nx(); chk("bb_stepdone", 0, 1, 17, 0);

        nx(); rst = 1'b1;
        nx(); rst = 1'b0; chk("rst2", 0, 1, 0, 0);
        nx(); halt = 1'b0; chk("run_rel", 0, 1, 0, 0);
        nx(); chk("run_first", 1, 0, 0, 0);
        repeat (15) nx();
        chk("run_16", 1, 0, 15, 0);
        nx(); halt = 1'b1; chk("run_match", 0, 0, 16, 0);
        nx(); chk("run_hit", 0, 1, 16, 1);
        nx(); chk("run_hit_once", 0, 1, 16, 0);
        nx(); halt = 1'b0; chk("run_resume_req", 0, 1, 16, 0);
        nx(); chk("run_resume", 1, 0, 16, 0);
        nx(); halt = 1'b1; chk("run_resume2", 1, 0, 17, 0);
        nx(); chk("run_halt", 0, 1, 18, 0);

        nx(); nx();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL queue_drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
